// File: rtl/bytemask_gen_pkg.sv
// Shared definitions for the feature-map SRAM write controller: FSM states,
// write modes and the lane-to-bytemask helper.
package bytemask_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic MODE_UNSHUFFLE = 1'b0;
    localparam logic MODE_FULL      = 1'b1;

    localparam int MAX_WORD_BYTES = 64;

    // Lane 0 is the most significant byte of the word, so its enable sits at
    // the top of the mask; every other byte stays disabled (1).
    function automatic logic [MAX_WORD_BYTES-1:0] lane_to_mask(input int lane, input int word_bytes);
        logic [MAX_WORD_BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_WORD_BYTES; i++) begin
            if (i < word_bytes) begin
                m[i] = (i != (word_bytes - 1 - lane));
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/bytemask_gen_pos_counter.sv
// Raster position tracker: x/y pixel coordinates plus a linear word index,
// each wrapping at the map boundary, with last-beat flags for both modes.
module pos_counter #(
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int WORD_BYTES = 16,
    parameter int XW         = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    parameter int YW         = (IMG_H > 1) ? $clog2(IMG_H) : 1,
    parameter int WW         = ((IMG_W * IMG_H / WORD_BYTES) > 1) ? $clog2(IMG_W * IMG_H / WORD_BYTES) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          adv_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic [WW-1:0] widx_o,
    output logic          last_pix_o,
    output logic          last_word_o
);

    localparam int NWORDS = IMG_W * IMG_H / WORD_BYTES;

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [WW-1:0] w_q, w_d;

    logic xAtEnd, yAtEnd, wAtEnd;

    assign xAtEnd = (x_q == XW'(IMG_W - 1));
    assign yAtEnd = (y_q == YW'(IMG_H - 1));
    assign wAtEnd = (w_q == WW'(NWORDS - 1));

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        w_d = w_q;
        if (clr_i) begin
            x_d = '0;
            y_d = '0;
            w_d = '0;
        end else if (adv_i) begin
            w_d = wAtEnd ? '0 : w_q + 1'b1;
            if (xAtEnd) begin
                x_d = '0;
                y_d = yAtEnd ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
            w_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            w_q <= w_d;
        end
    end

    assign x_o         = x_q;
    assign y_o         = y_q;
    assign widx_o      = w_q;
    assign last_pix_o  = xAtEnd && yAtEnd;
    assign last_word_o = wAtEnd;

endmodule

// File: rtl/bytemask_gen.sv
// Feature-map SRAM write controller: turns a raster pixel/word stream into
// registered SRAM writes with an active-low byte mask (unshuffle or full-word).
module bytemask_gen
    import bytemask_gen_pkg::*;
#(
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int BLK        = 4,
    parameter int ADDR_W     = 10,
    parameter int WORD_BYTES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mode,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORD_BYTES*8-1:0] in_data,
    output logic                    sram_wen,
    output logic [ADDR_W-1:0]       sram_addr,
    output logic [WORD_BYTES*8-1:0] sram_wdata,
    output logic [WORD_BYTES-1:0]   sram_bytemask,
    output logic                    busy,
    output logic                    done
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int WW = ((IMG_W * IMG_H / WORD_BYTES) > 1) ? $clog2(IMG_W * IMG_H / WORD_BYTES) : 1;

    state_e                  state_q, state_d;
    logic                    mode_q, mode_d;
    logic [ADDR_W-1:0]       base_q, base_d;
    logic                    wen_q, wen_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [WORD_BYTES*8-1:0] wdata_q, wdata_d;
    logic [WORD_BYTES-1:0]   mask_q, mask_d;

    logic          accept, cntClr, lastBeat;
    logic [XW-1:0] posX;
    logic [YW-1:0] posY;
    logic [WW-1:0] wordIdx;
    logic          lastPix, lastWord;

    assign in_ready = (state_q == ST_RUN);
    assign accept   = in_valid && in_ready;
    assign cntClr   = clear || ((state_q == ST_IDLE) && start);
    assign lastBeat = (mode_q == MODE_FULL) ? lastWord : lastPix;

    pos_counter #(
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .WORD_BYTES (WORD_BYTES),
        .XW         (XW),
        .YW         (YW),
        .WW         (WW)
    ) u_pos (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (cntClr),
        .adv_i       (accept),
        .x_o         (posX),
        .y_o         (posY),
        .widx_o      (wordIdx),
        .last_pix_o  (lastPix),
        .last_word_o (lastWord)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        base_d  = base_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_RUN;
                        mode_d  = mode;
                        base_d  = base_addr;
                    end
                end
                ST_RUN: begin
                    if (accept && lastBeat) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A beat accepted on the same cycle as clear is dropped; address and data
    // keep their last written values whenever no write is issued.
    always_comb begin
        int lane;
        wen_d   = 1'b0;
        mask_d  = '1;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        lane    = int'(posY % YW'(BLK)) * BLK + int'(posX % XW'(BLK));
        if (accept && !clear) begin
            wen_d = 1'b1;
            if (mode_q == MODE_FULL) begin
                mask_d  = '0;
                addr_d  = base_q + ADDR_W'(wordIdx);
                wdata_d = in_data;
            end else begin
                mask_d  = WORD_BYTES'(lane_to_mask(lane, WORD_BYTES));
                addr_d  = base_q
                        + ADDR_W'(posY / YW'(BLK)) * ADDR_W'(IMG_W / BLK)
                        + ADDR_W'(posX / XW'(BLK));
                wdata_d = {WORD_BYTES{in_data[7:0]}};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_UNSHUFFLE;
            base_q  <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '1;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            base_q  <= base_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
        end
    end

    assign sram_wen      = wen_q;
    assign sram_addr     = addr_q;
    assign sram_wdata    = wdata_q;
    assign sram_bytemask = mask_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_bytemask_gen.sv
// Self-checking bench for bytemask_gen: table vectors, randomized maps against
// a coordinate-based reference model, and clear/reset/start corner sequences.
module tb_bytemask_gen;

    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;
    localparam int BLK    = 4;
    localparam int ADDR_W = 10;
    localparam int WB     = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               mode;
    logic [ADDR_W-1:0]  base_addr;
    logic               clear;
    logic               in_valid;
    logic               in_ready;
    logic [WB*8-1:0]    in_data;
    logic               sram_wen;
    logic [ADDR_W-1:0]  sram_addr;
    logic [WB*8-1:0]    sram_wdata;
    logic [WB-1:0]      sram_bytemask;
    logic               busy;
    logic               done;

    bytemask_gen #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .BLK(BLK), .ADDR_W(ADDR_W), .WORD_BYTES(WB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .mode          (mode),
        .base_addr     (base_addr),
        .clear         (clear),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .sram_wen      (sram_wen),
        .sram_addr     (sram_addr),
        .sram_wdata    (sram_wdata),
        .sram_bytemask (sram_bytemask),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nErrors = 0;
    int nWrites = 0;
    int nDones  = 0;

    // Reference model: 0 = idle, 1 = streaming, 2 = done pulse
    int               mState = 0;
    bit               mMode  = 1'b0;
    int               mBase  = 0;
    int               mCount = 0;
    logic             expWen  = 1'b0;
    logic [ADDR_W-1:0] expAddr = '0;
    logic [WB*8-1:0]  expData = '0;
    logic [WB-1:0]    expMask = '1;

    typedef struct {
        logic        md;
        logic [9:0]  base;
        int          k;
        logic [7:0]  b;
        logic [9:0]  eAddr;
        logic [15:0] eMask;
    } vec_t;

    vec_t vecs[7];

    function automatic int totalBeats(input bit md);
        return md ? (IMG_W * IMG_H / WB) : (IMG_W * IMG_H);
    endfunction

    function automatic logic [WB*8-1:0] rndWord();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic refWrite(input bit md, input int base, input int k, input logic [WB*8-1:0] din,
                            output logic [ADDR_W-1:0] a, output logic [WB-1:0] m,
                            output logic [WB*8-1:0] d);
        int x, y, lane;
        if (md) begin
            a = ADDR_W'((base + k) % (1 << ADDR_W));
            m = '0;
            d = din;
        end else begin
            x    = k % IMG_W;
            y    = k / IMG_W;
            lane = (y % BLK) * BLK + (x % BLK);
            m    = '1;
            m[WB - 1 - lane] = 1'b0;
            a    = ADDR_W'((base + (y / BLK) * (IMG_W / BLK) + (x / BLK)) % (1 << ADDR_W));
            d    = {WB{din[7:0]}};
        end
    endtask

    task automatic checkVal(input string name, input logic [WB*8-1:0] act, input logic [WB*8-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        checkVal("wen",     128'(sram_wen),      128'(expWen));
        checkVal("addr",    128'(sram_addr),     128'(expAddr));
        checkVal("wdata",   sram_wdata,          expData);
        checkVal("mask",    128'(sram_bytemask), 128'(expMask));
        checkVal("done",    128'(done),          128'(mState == 2));
        checkVal("busy",    128'(busy),          128'(mState != 0));
        checkVal("inReady", 128'(in_ready),      128'(mState == 1));
        if (sram_wen) nWrites++;
        if (done) nDones++;
    endtask

    task automatic applyStimulus(input logic st, input logic md, input logic [ADDR_W-1:0] ba,
                                 input logic cl, input logic vl, input logic [WB*8-1:0] dt);
        int nState;
        start     = st;
        mode      = md;
        base_addr = ba;
        clear     = cl;
        in_valid  = vl;
        in_data   = dt;
        nState    = mState;
        expWen    = 1'b0;
        expMask   = '1;
        if (cl) begin
            nState = 0;
        end else begin
            case (mState)
                0: if (st) begin
                    mMode  = md;
                    mBase  = int'(ba);
                    mCount = 0;
                    nState = 1;
                end
                1: if (vl) begin
                    refWrite(mMode, mBase, mCount, dt, expAddr, expMask, expData);
                    expWen = 1'b1;
                    mCount++;
                    if (mCount == totalBeats(mMode)) nState = 2;
                end
                default: nState = 0;
            endcase
        end
        @(posedge clk);
        #1;
        mState = nState;
        checkOutput();
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic runMap(input bit md, input logic [ADDR_W-1:0] ba, input int gapPct);
        int cyc;
        logic st;
        nWrites = 0;
        nDones  = 0;
        applyStimulus(1'b1, md, ba, 1'b0, 1'b0, '0);
        cyc = 0;
        while (mState != 0 && cyc < 20000) begin
            st = ($urandom_range(0, 49) == 0);
            applyStimulus(st, ~md, ADDR_W'($urandom()), 1'b0,
                          ($urandom_range(0, 99) >= gapPct), rndWord());
            cyc++;
        end
        checkVal("mapWrites", 128'(nWrites), 128'(totalBeats(md)));
        checkVal("mapDones",  128'(nDones),  128'(1));
        idleCycle();
    endtask

    initial begin
        logic [WB*8-1:0] dt;
        int cyc;

        vecs[0] = '{1'b0, 10'h040, 0,   8'hA5, 10'h040, 16'h7FFF};
        vecs[1] = '{1'b0, 10'h040, 61,  8'h3C, 10'h041, 16'hFFBF};
        vecs[2] = '{1'b0, 10'h040, 783, 8'h5A, 10'h070, 16'hFFFE};
        vecs[3] = '{1'b0, 10'h3FF, 4,   8'h11, 10'h000, 16'h7FFF};
        vecs[4] = '{1'b0, 10'h000, 29,  8'hC3, 10'h000, 16'hFBFF};
        vecs[5] = '{1'b1, 10'h100, 48,  8'h77, 10'h130, 16'h0000};
        vecs[6] = '{1'b1, 10'h3F0, 20,  8'h9E, 10'h004, 16'h0000};

        rst = 1'b1; start = 1'b0; mode = 1'b0; base_addr = '0;
        clear = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput();
        rst = 1'b0;
        idleCycle();

        for (int v = 0; v < 7; v++) begin
            applyStimulus(1'b1, vecs[v].md, vecs[v].base, 1'b0, 1'b0, '0);
            for (int i = 0; i <= vecs[v].k; i++) begin
                dt = rndWord();
                if (i == vecs[v].k) dt = vecs[v].md ? {WB{vecs[v].b}} : {dt[WB*8-1:8], vecs[v].b};
                applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, dt);
            end
            checkVal("vecWen",   128'(sram_wen),      128'(1));
            checkVal("vecAddr",  128'(sram_addr),     128'(vecs[v].eAddr));
            checkVal("vecMask",  128'(sram_bytemask), 128'(vecs[v].eMask));
            checkVal("vecWdata", sram_wdata,          {WB{vecs[v].b}});
            if (mState != 0) applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
            idleCycle();
        end

        runMap(1'b0, 10'h040, 30);
        runMap(1'b1, 10'h100, 30);
        runMap(1'b1, 10'h3F8, 10);

        // clear after ten accepted beats while in_valid stays high
        nWrites = 0;
        nDones  = 0;
        applyStimulus(1'b1, 1'b0, 10'h020, 1'b0, 1'b0, '0);
        cyc = 0;
        while (mCount < 10 && cyc < 100) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, rndWord());
            cyc++;
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, rndWord());
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, rndWord());
        checkVal("clearWrites",  128'(nWrites <= 10), 128'(1));
        checkVal("clearNoDone",  128'(nDones),        128'(0));
        checkVal("clearInReady", 128'(in_ready),      128'(0));
        runMap(1'b0, 10'h200, 20);

        // asynchronous reset mid-map
        applyStimulus(1'b1, 1'b0, 10'h080, 1'b0, 1'b0, '0);
        for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, rndWord());
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkVal("rstWen",   128'(sram_wen),      128'(0));
        checkVal("rstAddr",  128'(sram_addr),     128'(0));
        checkVal("rstWdata", sram_wdata,          128'(0));
        checkVal("rstMask",  128'(sram_bytemask), 128'(16'hFFFF));
        checkVal("rstBusy",  128'(busy),          128'(0));
        checkVal("rstReady", 128'(in_ready),      128'(0));
        checkVal("rstDone",  128'(done),          128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        mState = 0; mCount = 0; expWen = 1'b0; expMask = '1; expAddr = '0; expData = '0;
        idleCycle();

        // clear and start together: clear wins
        applyStimulus(1'b1, 1'b1, 10'h055, 1'b1, 1'b1, rndWord());
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, rndWord());

        runMap(1'b1, 10'h000, 50);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
